// File: rtl/ra_2r1w_64x72_bist_pkg.sv
// Shared types and constants for the 2R1W 64x72 array march BIST.
// BIST_FAILLOG_EN adds the address field that the first-failure log needs.
package ra_2r1w_64x72_bist_pkg;

  localparam int ADR_W = 6;
  localparam int DAT_W = 72;
  localparam int CNT_W = 8;

  localparam logic [0:ADR_W-1] ADR_MAX = '1;
  localparam logic [0:CNT_W-1] CNT_MAX = '1;
  localparam logic [0:DAT_W-1] PAT_A   = {36{2'b10}};
  localparam logic [0:DAT_W-1] PAT_5   = {36{2'b01}};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR0,
    ST_TA0,
    ST_RD0,
    ST_WR1,
    ST_TA1,
    ST_RD1,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  // One in-flight read: per-port valid and expected data.
  typedef struct packed {
    logic             vld0;
    logic [0:DAT_W-1] exp0;
    logic             vld1;
    logic [0:DAT_W-1] exp1;
`ifdef BIST_FAILLOG_EN
    logic [0:ADR_W-1] adr;
`endif
  } cmp_ent_t;

  typedef logic [CNT_W:0] cnt_sum_t;

  // Address bit ADR_W-1 is the LSB, so odd addresses get the 0101.. pattern.
  function automatic logic [0:DAT_W-1] pattern(logic [0:ADR_W-1] adr, logic inv);
    return (adr[ADR_W-1] ? PAT_5 : PAT_A) ^ {DAT_W{inv}};
  endfunction

  function automatic logic [0:CNT_W-1] sat_add(logic [0:CNT_W-1] cnt, logic f0, logic f1);
    cnt_sum_t sum;
    sum = cnt_sum_t'(cnt) + cnt_sum_t'(f0) + cnt_sum_t'(f1);
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ra_2r1w_64x72_bist_if.sv
// Array-side port bundle between the BIST sequencer (master) and the 2R1W array wrapper (slave).
interface ra_2r1w_64x72_bist_if;
  import ra_2r1w_64x72_bist_pkg::*;

  logic             rd_enb_0;
  logic [0:ADR_W-1] rd_adr_0;
  logic [0:DAT_W-1] rd_dat_0;
  logic             rd_enb_1;
  logic [0:ADR_W-1] rd_adr_1;
  logic [0:DAT_W-1] rd_dat_1;
  logic             wr_enb_0;
  logic [0:ADR_W-1] wr_adr_0;
  logic [0:DAT_W-1] wr_dat_0;

  modport master (
    output rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1, wr_enb_0, wr_adr_0, wr_dat_0,
    input  rd_dat_0, rd_dat_1
  );

  modport slave (
    input  rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1, wr_enb_0, wr_adr_0, wr_dat_0,
    output rd_dat_0, rd_dat_1
  );
endinterface

// File: rtl/ra_bist_cmp_pipe.sv
// Delays expected read data by RD_LAT cycles and compares it against both array read ports.
// BIST_FAILLOG_EN also carries the port-0 read address to the tail.
module ra_bist_cmp_pipe
  import ra_2r1w_64x72_bist_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  cmp_ent_t         ent,
  input  logic [0:DAT_W-1] rd_dat_0,
  input  logic [0:DAT_W-1] rd_dat_1,
`ifdef BIST_FAILLOG_EN
  output logic [0:ADR_W-1] tail_adr,
`endif
  output logic             fail0,
  output logic             fail1
);

  cmp_ent_t pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this delay line is reset on purpose; stale valid bits would be counted after a mid-run reset.
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= ent;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign fail0 = pipe_q[RD_LAT-1].vld0 && (rd_dat_0 != pipe_q[RD_LAT-1].exp0);
  assign fail1 = pipe_q[RD_LAT-1].vld1 && (rd_dat_1 != pipe_q[RD_LAT-1].exp1);

`ifdef BIST_FAILLOG_EN
  assign tail_adr = pipe_q[RD_LAT-1].adr;
`endif

endmodule

// File: rtl/ra_2r1w_64x72_bist.sv
// March BIST sequencer for the 2R1W 64x72 array: write P, read P on both ports, write ~P, read ~P.
// BIST_FAILLOG_EN adds fail_vld/fail_port/fail_adr/fail_dat capturing the first failing compare.
module ra_2r1w_64x72_bist
  import ra_2r1w_64x72_bist_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [0:CNT_W-1] fail_cnt,
`ifdef BIST_FAILLOG_EN
  output logic             fail_vld,
  output logic             fail_port,
  output logic [0:ADR_W-1] fail_adr,
  output logic [0:DAT_W-1] fail_dat,
`endif
  ra_2r1w_64x72_bist_if.master arr
);

  bist_state_e      state_q, state_d;
  logic [0:ADR_W-1] idx_q, idx_d;
  logic [7:0]       drain_q, drain_d;
  logic [0:CNT_W-1] fail_cnt_q;
  logic             start_ok;
  logic             inv;
  cmp_ent_t         ent;
  logic             fail0, fail1;
`ifdef BIST_FAILLOG_EN
  logic [0:ADR_W-1] tail_adr;
`endif

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign inv      = (state_q == ST_WR1 || state_q == ST_RD1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    drain_d      = drain_q;
    arr.rd_enb_0 = 1'b0;
    arr.rd_adr_0 = '0;
    arr.rd_enb_1 = 1'b0;
    arr.rd_adr_1 = '0;
    arr.wr_enb_0 = 1'b0;
    arr.wr_adr_0 = '0;
    arr.wr_dat_0 = '0;
    ent          = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WR0;
          idx_d   = '0;
        end
      end
      ST_WR0, ST_WR1: begin
        arr.wr_enb_0 = 1'b1;
        arr.wr_adr_0 = idx_q;
        arr.wr_dat_0 = pattern(idx_q, inv);
        idx_d        = idx_q + ADR_W'(1);
        if (idx_q == ADR_MAX) state_d = (state_q == ST_WR0) ? ST_TA0 : ST_TA1;
      end
      ST_TA0: state_d = ST_RD0;
      ST_TA1: state_d = ST_RD1;
      ST_RD0, ST_RD1: begin
        // Port 1 walks the array top-down while port 0 walks bottom-up.
        arr.rd_enb_0 = 1'b1;
        arr.rd_adr_0 = idx_q;
        arr.rd_enb_1 = 1'b1;
        arr.rd_adr_1 = ADR_MAX - idx_q;
        ent.vld0     = 1'b1;
        ent.exp0     = pattern(idx_q, inv);
        ent.vld1     = 1'b1;
        ent.exp1     = pattern(ADR_MAX - idx_q, inv);
`ifdef BIST_FAILLOG_EN
        ent.adr      = idx_q;
`endif
        idx_d        = idx_q + ADR_W'(1);
        if (idx_q == ADR_MAX) begin
          state_d = (state_q == ST_RD0) ? ST_WR1 : ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 8'd1;
        if (drain_q == 8'(RD_LAT - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ra_bist_cmp_pipe #(.RD_LAT(RD_LAT)) u_cmp (
    .clk      (clk),
    .reset    (reset),
    .ent      (ent),
    .rd_dat_0 (arr.rd_dat_0),
    .rd_dat_1 (arr.rd_dat_1),
`ifdef BIST_FAILLOG_EN
    .tail_adr (tail_adr),
`endif
    .fail0    (fail0),
    .fail1    (fail1)
  );

  always_ff @(posedge clk) begin
    if (reset || start_ok) fail_cnt_q <= '0;
    else                   fail_cnt_q <= sat_add(fail_cnt_q, fail0, fail1);
  end

`ifdef BIST_FAILLOG_EN
  // Port 0 wins a same-cycle tie; port 1's address is the mirror of port 0's.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      fail_vld  <= 1'b0;
      fail_port <= 1'b0;
      fail_adr  <= '0;
      fail_dat  <= '0;
    end else if (!fail_vld && (fail0 || fail1)) begin
      fail_vld  <= 1'b1;
      fail_port <= !fail0;
      fail_adr  <= fail0 ? tail_adr : ADR_MAX - tail_adr;
      fail_dat  <= fail0 ? arr.rd_dat_0 : arr.rd_dat_1;
    end
  end
`endif

  assign busy     = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign pass     = done && (fail_cnt_q == '0);
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_ra_2r1w_64x72_bist.sv
// Bench for ra_2r1w_64x72_bist: lane 0 uses RD_LAT=2, lane 1 RD_LAT=1, each with a faultable array model.
// A phase-arithmetic reference model predicts every output each cycle; BIST_FAILLOG_EN adds log checks.
module tb_ra_2r1w_64x72_bist;
  import ra_2r1w_64x72_bist_pkg::*;

  typedef struct packed {
    logic        rd_enb_0;
    logic [5:0]  rd_adr_0;
    logic        rd_enb_1;
    logic [5:0]  rd_adr_1;
    logic        wr_enb_0;
    logic [5:0]  wr_adr_0;
    logic [71:0] wr_dat_0;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       start;
  logic [1:0]       busy, done, pass;
  logic [1:0][7:0]  fail_cnt;
  obs_t [1:0]       obs;
  int               fault_mode [2];
`ifdef BIST_FAILLOG_EN
  logic [1:0]       fl_vld, fl_port;
  logic [1:0][5:0]  fl_adr;
  logic [1:0][71:0] fl_dat;
`endif

  int   n_cmp = 0;
  int   n_fail = 0;
  logic cmp_en = 1'b0;
  int   busy_cyc [2] = '{0, 0};

  // Reference model state.
  logic m_busy [2] = '{1'b0, 1'b0};
  logic m_done [2] = '{1'b0, 1'b0};
  int   m_k    [2] = '{0, 0};
  int   m_cnt  [2] = '{0, 0};
  int   due    [2][264];

  // Odd addresses hold 0101.. (hex 5s), even ones 1010.. (hex As).
  function automatic logic [71:0] pat(int a, logic inv);
    logic [71:0] p;
    p = (a % 2 == 1) ? 72'h555555555555555555 : 72'hAAAAAAAAAAAAAAAAAA;
    return inv ? ~p : p;
  endfunction

  // Mode 1: array bit 0 (the MSB) of address 5 stuck at 0. Mode 2: reads return all zeros.
  function automatic logic [71:0] fault_rd(int mode, int adr, logic [71:0] d);
    logic [71:0] r;
    r = d;
    if (mode == 1 && adr == 5) r[71] = 1'b0;
    if (mode == 2) r = '0;
    return r;
  endfunction

  // Array accesses expected in busy cycle k (k = 0 is the first busy cycle).
  function automatic obs_t exp_obs(int k);
    obs_t e;
    int   i;
    e = '0;
    if (k < 64) begin
      e.wr_enb_0 = 1'b1; e.wr_adr_0 = 6'(k); e.wr_dat_0 = pat(k, 1'b0);
    end else if (k >= 65 && k < 129) begin
      i = k - 65;
      e.rd_enb_0 = 1'b1; e.rd_adr_0 = 6'(i); e.rd_enb_1 = 1'b1; e.rd_adr_1 = 6'(63 - i);
    end else if (k >= 129 && k < 193) begin
      i = k - 129;
      e.wr_enb_0 = 1'b1; e.wr_adr_0 = 6'(i); e.wr_dat_0 = pat(i, 1'b1);
    end else if (k >= 194 && k < 258) begin
      i = k - 194;
      e.rd_enb_0 = 1'b1; e.rd_adr_0 = 6'(i); e.rd_enb_1 = 1'b1; e.rd_adr_1 = 6'(63 - i);
    end
    return e;
  endfunction

  function automatic int rd_fails(int mode, int k);
    obs_t        e;
    logic        inv;
    logic [71:0] x;
    int          n;
    e   = exp_obs(k);
    inv = (k >= 129);
    n   = 0;
    if (e.rd_enb_0) begin
      x = pat(int'(e.rd_adr_0), inv);
      if (fault_rd(mode, int'(e.rd_adr_0), x) != x) n++;
      x = pat(int'(e.rd_adr_1), inv);
      if (fault_rd(mode, int'(e.rd_adr_1), x) != x) n++;
    end
    return n;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = 2 - g;
    ra_2r1w_64x72_bist_if bif ();

    ra_2r1w_64x72_bist #(.RD_LAT(LAT)) dut (
      .clk       (clk),
      .reset     (rst[g]),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .fail_cnt  (fail_cnt[g]),
`ifdef BIST_FAILLOG_EN
      .fail_vld  (fl_vld[g]),
      .fail_port (fl_port[g]),
      .fail_adr  (fl_adr[g]),
      .fail_dat  (fl_dat[g]),
`endif
      .arr       (bif)
    );

    logic [71:0] mem [64];
    logic [71:0] q0 [LAT];
    logic [71:0] q1 [LAT];

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    always @(posedge clk) begin
      if (bif.wr_enb_0) mem[bif.wr_adr_0] <= bif.wr_dat_0;
      q0[0] <= fault_rd(fault_mode[g], int'(bif.rd_adr_0), mem[bif.rd_adr_0]);
      q1[0] <= fault_rd(fault_mode[g], int'(bif.rd_adr_1), mem[bif.rd_adr_1]);
      for (int i = 1; i < LAT; i++) begin
        q0[i] <= q0[i-1];
        q1[i] <= q1[i-1];
      end
    end

    assign bif.rd_dat_0 = q0[LAT-1];
    assign bif.rd_dat_1 = q1[LAT-1];
    assign obs[g] = {bif.rd_enb_0, bif.rd_adr_0, bif.rd_enb_1, bif.rd_adr_1,
                     bif.wr_enb_0, bif.wr_adr_0, bif.wr_dat_0};
  end

  // Reference model: busy for 258+lat cycles; each read's mismatches land lat cycles later.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rst[l]) begin
        m_busy[l] = 1'b0; m_done[l] = 1'b0; m_cnt[l] = 0; m_k[l] = 0;
      end else if (!m_busy[l] && start[l]) begin
        m_busy[l] = 1'b1; m_done[l] = 1'b0; m_cnt[l] = 0; m_k[l] = 0;
        for (int j = 0; j < 264; j++) due[l][j] = 0;
      end else if (m_busy[l]) begin
        m_cnt[l] = (m_cnt[l] + due[l][m_k[l]] > 255) ? 255 : m_cnt[l] + due[l][m_k[l]];
        m_k[l]++;
        if (m_k[l] == 258 + (2 - l)) begin
          m_busy[l] = 1'b0; m_done[l] = 1'b1;
        end else begin
          due[l][m_k[l] + (2 - l)] += rd_fails(fault_mode[l], m_k[l]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int l = 0; l < 2; l++) begin
        if (busy[l]) busy_cyc[l]++;
        check($sformatf("L%0d_busy", l), 128'(busy[l]), 128'(m_busy[l]));
        check($sformatf("L%0d_done", l), 128'(done[l]), 128'(m_done[l]));
        check($sformatf("L%0d_pass", l), 128'(pass[l]), 128'(m_done[l] && m_cnt[l] == 0));
        check($sformatf("L%0d_fail_cnt", l), 128'(fail_cnt[l]), 128'(m_cnt[l]));
        check($sformatf("L%0d_array_ports", l), 128'(obs[l]),
              128'(m_busy[l] ? exp_obs(m_k[l]) : obs_t'('0)));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(int l);
    start[l] = 1'b1;
    step();
    start[l] = 1'b0;
  endtask

  task automatic wait_done(int l, int budget);
    int n;
    n = 0;
    while (!done[l] && n < budget) begin
      step();
      n++;
    end
    check($sformatf("L%0d_done_in_time", l), 128'(done[l]), 128'(1));
  endtask

  int b0, b1;

  initial begin
    rst = 2'b11;
    start = 2'b00;
    fault_mode[0] = 0;
    fault_mode[1] = 0;
    @(posedge clk);
    @(posedge clk);
    step();
    cmp_en = 1'b1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_fail_cnt", 128'(fail_cnt), 128'(0));
    check("rst_ports", 128'(obs[0]), 128'(0));
    rst = 2'b00;
    repeat (6) step();

    // Clean array on both lanes, started together around cycle 10.
    b0 = busy_cyc[0];
    b1 = busy_cyc[1];
    start = 2'b11;
    step();
    start = 2'b00;
    wait_done(0, 400);
    wait_done(1, 400);
    check("t1_busy_cycles", 128'(busy_cyc[0] - b0), 128'(260));
    check("t1_pass", 128'(pass[0]), 128'(1));
    check("t1_fail_cnt", 128'(fail_cnt[0]), 128'(0));
    check("t6_busy_cycles", 128'(busy_cyc[1] - b1), 128'(259));
    check("t6_pass", 128'(pass[1]), 128'(1));

    // Stuck-at-0 on bit 0 of address 5: only the ~P read phase sees it, once per port.
    fault_mode[0] = 1;
    pulse_start(0);
    wait_done(0, 400);
    check("t2_fail_cnt", 128'(fail_cnt[0]), 128'(2));
    check("t2_pass", 128'(pass[0]), 128'(0));
`ifdef BIST_FAILLOG_EN
    check("t2_log_vld", 128'(fl_vld[0]), 128'(1));
    check("t2_log_port", 128'(fl_port[0]), 128'(0));
    check("t2_log_adr", 128'(fl_adr[0]), 128'(5));
    check("t2_log_dat", 128'(fl_dat[0]), 128'(72'h2AAAAAAAAAAAAAAAAA));
`endif

    // All reads return zero: 256 failing compares saturate at 255.
    fault_mode[0] = 2;
    pulse_start(0);
    wait_done(0, 400);
    check("t3_fail_cnt", 128'(fail_cnt[0]), 128'(255));
    check("t3_pass", 128'(pass[0]), 128'(0));

    // Reset in the middle of the first read phase, then a clean rerun.
    pulse_start(0);
    repeat (88) step();
    check("t4_cnt_before_reset", 128'(fail_cnt[0] != 8'd0), 128'(1));
    rst[0] = 1'b1;
    step();
    check("t4_ports_idle", 128'(obs[0]), 128'(0));
    check("t4_busy", 128'(busy[0]), 128'(0));
    check("t4_fail_cnt", 128'(fail_cnt[0]), 128'(0));
    rst[0] = 1'b0;
    fault_mode[0] = 0;
    b0 = busy_cyc[0];
    pulse_start(0);
    wait_done(0, 400);
    check("t4_busy_cycles", 128'(busy_cyc[0] - b0), 128'(260));
    check("t4_pass", 128'(pass[0]), 128'(1));

    // Start pulsed during the second write phase is ignored; start in DONE reruns.
    b0 = busy_cyc[0];
    pulse_start(0);
    repeat (148) step();
    pulse_start(0);
    wait_done(0, 400);
    check("t5_busy_cycles", 128'(busy_cyc[0] - b0), 128'(260));
    pulse_start(0);
    check("t5_done_dropped", 128'(done[0]), 128'(0));
    check("t5_busy_again", 128'(busy[0]), 128'(1));
    wait_done(0, 400);
    check("t5_pass", 128'(pass[0]), 128'(1));

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
